traffic_light_checker: RTL and testbench

- Receiving end of the traffic-light output interface: samples R/G/Y and pass every clock and checks them against the required light schedule.
- Sits beside the light controller in the top-level and in benches.
- Tracks the schedule position independently and flags illegal encodings and wrong-phase lights.
- Reports first-error position, error counts, completed schedule cycles and pass-restart counts.

---
 rtl/traffic_light_checker_pkg.sv | 41 ++++
 rtl/traffic_light_checker_if.sv | 14 +
 rtl/traffic_schedule_pos.sv | 59 +++++
 rtl/traffic_light_checker.sv | 99 +++++++++
 tb/tb_traffic_light_checker.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_checker_pkg.sv
// rtl/traffic_light_checker_pkg.sv - shared phase/error encodings and schedule defaults
//
// Purpose: constants shared by the light checker and the light controller.
// Contents: phase_t (schedule phase), err_code_t (first-error type),
//           default segment lengths, expected_lights() helper.
package traffic_light_checker_pkg;

  typedef enum logic [2:0] {
    PH_G0   = 3'd0,
    PH_OFF1 = 3'd1,
    PH_G1   = 3'd2,
    PH_OFF2 = 3'd3,
    PH_G2   = 3'd4,
    PH_YEL  = 3'd5,
    PH_RED  = 3'd6
  } phase_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MULTI = 2'd1,
    ERR_WRONG = 2'd2
  } err_code_t;

  localparam int DEF_G0_LEN    = 1024;
  localparam int DEF_BLINK_LEN = 128;
  localparam int DEF_Y_LEN     = 512;
  localparam int DEF_R_LEN     = 1024;
  localparam int DEF_POS_W     = 12;
  localparam int DEF_CNT_W     = 16;

  // Lights the controller must show in a phase, packed as {R, G, Y}.
  function automatic logic [2:0] expected_lights(input phase_t ph);
    case (ph)
      PH_G0, PH_G1, PH_G2: return 3'b010;
      PH_YEL:              return 3'b001;
      PH_RED:              return 3'b100;
      default:             return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_checker_if.sv
// rtl/traffic_light_checker_if.sv - traffic-light output bundle (pass request plus R/G/Y)
//
// Purpose: groups the signals the light controller drives and the checker observes.
// Signals: pass (pedestrian request), R, G, Y (light outputs).
// Modports: master drives the bundle, slave observes it.
interface traffic_light_checker_if;
  logic pass;
  logic R;
  logic G;
  logic Y;

  modport master (output pass, output R, output G, output Y);
  modport slave  (input pass, input R, input G, input Y);
endinterface

// File: rtl/traffic_schedule_pos.sv
// rtl/traffic_schedule_pos.sv - light schedule position counter with phase decode
//
// Purpose: tracks the position inside the light schedule and decodes the phase.
// Ports: clk, rst (async active-low), pass (restart request, ignored in G0),
//        pos (current position), phase (decoded from pos, same cycle),
//        wrap (pos returns to 0 at schedule end this edge),
//        restart (pos returns to 0 due to pass this edge).
module traffic_schedule_pos
  import traffic_light_checker_pkg::*;
#(
  parameter int G0_LEN    = DEF_G0_LEN,
  parameter int BLINK_LEN = DEF_BLINK_LEN,
  parameter int Y_LEN     = DEF_Y_LEN,
  parameter int R_LEN     = DEF_R_LEN,
  parameter int POS_W     = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pass,
  output logic [POS_W-1:0] pos,
  output phase_t           phase,
  output logic             wrap,
  output logic             restart
);

  // First position of each phase after G0, and the last schedule position.
  localparam logic [POS_W-1:0] OFF1_START = POS_W'(G0_LEN);
  localparam logic [POS_W-1:0] G1_START   = POS_W'(G0_LEN + BLINK_LEN);
  localparam logic [POS_W-1:0] OFF2_START = POS_W'(G0_LEN + 2*BLINK_LEN);
  localparam logic [POS_W-1:0] G2_START   = POS_W'(G0_LEN + 3*BLINK_LEN);
  localparam logic [POS_W-1:0] YEL_START  = POS_W'(G0_LEN + 4*BLINK_LEN);
  localparam logic [POS_W-1:0] RED_START  = POS_W'(G0_LEN + 4*BLINK_LEN + Y_LEN);
  localparam logic [POS_W-1:0] LAST_POS   = POS_W'(G0_LEN + 4*BLINK_LEN + Y_LEN + R_LEN - 1);

  // A pass restart outranks the end-of-schedule wrap.
  assign restart = pass && (pos >= OFF1_START);
  assign wrap    = !restart && (pos == LAST_POS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= '0;
    end else if (restart || wrap) begin
      pos <= '0;
    end else begin
      pos <= pos + POS_W'(1);
    end
  end

  always_comb begin
    phase = PH_G0;
    if (pos >= RED_START)       phase = PH_RED;
    else if (pos >= YEL_START)  phase = PH_YEL;
    else if (pos >= G2_START)   phase = PH_G2;
    else if (pos >= OFF2_START) phase = PH_OFF2;
    else if (pos >= G1_START)   phase = PH_G1;
    else if (pos >= OFF1_START) phase = PH_OFF1;
  end

endmodule

// File: rtl/traffic_light_checker.sv
// rtl/traffic_light_checker.sv - checks observed lights against the required schedule
//
// Purpose: follows the light schedule independently of the controller and flags
//          multi-hot encodings and wrong-phase lights.
// Ports: clk, rst (async active-low), lights (slave: pass, R, G, Y),
//        clr_err (clear sticky error fields), pos/phase (expected position/phase),
//        err/err_code/err_pos (sticky first error), mismatch_cnt, wrap_cnt,
//        restart_cnt (saturating statistics).
module traffic_light_checker
  import traffic_light_checker_pkg::*;
#(
  parameter int G0_LEN    = DEF_G0_LEN,
  parameter int BLINK_LEN = DEF_BLINK_LEN,
  parameter int Y_LEN     = DEF_Y_LEN,
  parameter int R_LEN     = DEF_R_LEN,
  parameter int POS_W     = DEF_POS_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_light_checker_if.slave lights,
  input  logic                   clr_err,
  output logic [POS_W-1:0]       pos,
  output logic [2:0]             phase,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [POS_W-1:0]       err_pos,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic [CNT_W-1:0]       wrap_cnt,
  output logic [CNT_W-1:0]       restart_cnt
);

  phase_t    cur_phase;
  logic      wrap;
  logic      restart;
  logic      multi_hot;
  logic      r_obs;
  logic      g_obs;
  logic      y_obs;
  err_code_t code;

  traffic_schedule_pos #(
    .G0_LEN    (G0_LEN),
    .BLINK_LEN (BLINK_LEN),
    .Y_LEN     (Y_LEN),
    .R_LEN     (R_LEN),
    .POS_W     (POS_W)
  ) u_sched (
    .clk     (clk),
    .rst     (rst),
    .pass    (lights.pass),
    .pos     (pos),
    .phase   (cur_phase),
    .wrap    (wrap),
    .restart (restart)
  );

  assign phase = cur_phase;
  assign r_obs = lights.R;
  assign g_obs = lights.G;
  assign y_obs = lights.Y;

  assign multi_hot = (r_obs & g_obs) | (r_obs & y_obs) | (g_obs & y_obs);

  always_comb begin
    code = ERR_NONE;
    if (multi_hot) begin
      code = ERR_MULTI;
    end else if ({r_obs, g_obs, y_obs} != expected_lights(cur_phase)) begin
      code = ERR_WRONG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      err_pos      <= '0;
      mismatch_cnt <= '0;
      wrap_cnt     <= '0;
      restart_cnt  <= '0;
    end else begin
      // A new error in the same cycle as clr_err re-arms the capture.
      if ((code != ERR_NONE) && (!err || clr_err)) begin
        err      <= 1'b1;
        err_code <= code;
        err_pos  <= pos;
      end else if (clr_err) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
        err_pos  <= '0;
      end
      if ((code != ERR_NONE) && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (wrap && (wrap_cnt != '1))                   wrap_cnt     <= wrap_cnt + CNT_W'(1);
      if (restart && (restart_cnt != '1))             restart_cnt  <= restart_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_light_checker.sv
// tb/tb_traffic_light_checker.sv - self-checking bench for traffic_light_checker
module tb_traffic_light_checker;

  localparam int G0 = 1024;
  localparam int BL = 128;
  localparam int YL = 512;
  localparam int RL = 1024;
  localparam int L  = G0 + 4*BL + YL + RL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_err = 1'b0;
  logic [11:0] pos;
  logic [2:0]  phase;
  logic        err;
  logic [1:0]  err_code;
  logic [11:0] err_pos;
  logic [15:0] mismatch_cnt;
  logic [15:0] wrap_cnt;
  logic [15:0] restart_cnt;

  int checks = 0;
  int errors = 0;

  int m_pos = 0, m_err = 0, m_code = 0, m_err_pos = 0;
  int m_mism = 0, m_wrap = 0, m_rest = 0;

  traffic_light_checker_if lif ();

  traffic_light_checker dut (
    .clk          (clk),
    .rst          (rst),
    .lights       (lif),
    .clr_err      (clr_err),
    .pos          (pos),
    .phase        (phase),
    .err          (err),
    .err_code     (err_code),
    .err_pos      (err_pos),
    .mismatch_cnt (mismatch_cnt),
    .wrap_cnt     (wrap_cnt),
    .restart_cnt  (restart_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_l(input int p);
    if (p < G0) return 3'b010;
    if (p < G0 + 4*BL) return ((((p - G0) / BL) % 2) == 1) ? 3'b010 : 3'b000;
    if (p < G0 + 4*BL + YL) return 3'b001;
    return 3'b100;
  endfunction

  function automatic int exp_ph(input int p);
    if (p < G0) return 0;
    if (p < G0 + 4*BL) return 1 + (p - G0) / BL;
    if (p < G0 + 4*BL + YL) return 5;
    return 6;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == 65535) ? v : v + 1;
  endfunction

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_err = 0; m_code = 0; m_err_pos = 0;
    m_mism = 0; m_wrap = 0; m_rest = 0;
  endtask

  // Applies one clock edge worth of rules to the model using the inputs seen at that edge.
  task automatic model_update();
    logic [2:0] obs;
    int code;
    if (!rst) begin
      model_reset();
      return;
    end
    obs = {lif.R, lif.G, lif.Y};
    code = 0;
    if ($countones(obs) > 1) code = 1;
    else if (obs != exp_l(m_pos)) code = 2;
    if (code != 0) begin
      m_mism = sat_inc(m_mism);
      if (m_err == 0 || clr_err) begin
        m_err = 1; m_code = code; m_err_pos = m_pos;
      end
    end else if (clr_err) begin
      m_err = 0; m_code = 0; m_err_pos = 0;
    end
    if (lif.pass && m_pos >= G0) begin
      m_pos = 0; m_rest = sat_inc(m_rest);
    end else if (m_pos == L - 1) begin
      m_pos = 0; m_wrap = sat_inc(m_wrap);
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  always @(negedge clk) begin
    check("pos", int'(pos), m_pos);
    check("phase", int'(phase), exp_ph(m_pos));
    check("err", int'(err), m_err);
    check("err_code", int'(err_code), m_code);
    check("err_pos", int'(err_pos), m_err_pos);
    check("mismatch_cnt", int'(mismatch_cnt), m_mism);
    check("wrap_cnt", int'(wrap_cnt), m_wrap);
    check("restart_cnt", int'(restart_cnt), m_rest);
  end

  task automatic run_cycle(input logic p, input logic [2:0] l, input logic c);
    lif.pass = p;
    {lif.R, lif.G, lif.Y} = l;
    clr_err = c;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_pos != target && n < 4000) begin
      run_cycle(1'b0, exp_l(m_pos), 1'b0);
      n++;
    end
    check("reach_pos", int'(pos), target);
  endtask

  initial begin
    lif.pass = 1'b0;
    {lif.R, lif.G, lif.Y} = 3'b010;
    repeat (3) run_cycle(1'b0, 3'b010, 1'b0);
    check("reset_pos", int'(pos), 0);
    check("reset_err", int'(err), 0);
    check("reset_wrap", int'(wrap_cnt), 0);
    rst = 1'b1;

    for (int i = 0; i < L; i++) run_cycle(1'b0, exp_l(m_pos), 1'b0);
    check("pos_at_3072", int'(pos), 0);
    check("wrap_one", int'(wrap_cnt), 1);
    for (int i = 0; i < L; i++) run_cycle(1'b0, exp_l(m_pos), 1'b0);
    check("pos_at_6144", int'(pos), 0);
    check("wrap_two", int'(wrap_cnt), 2);
    check("clean_err", int'(err), 0);
    check("clean_mism", int'(mismatch_cnt), 0);

    run_to(300);
    run_cycle(1'b1, 3'b010, 1'b0);
    check("g0_pass_pos", int'(pos), 301);
    check("g0_pass_rest", int'(restart_cnt), 0);

    run_to(500);
    run_cycle(1'b0, 3'b000, 1'b0);
    check("e1_err", int'(err), 1);
    check("e1_code", int'(err_code), 2);
    check("e1_pos", int'(err_pos), 500);
    check("e1_mism", int'(mismatch_cnt), 1);

    run_to(600);
    run_cycle(1'b0, 3'b110, 1'b0);
    check("e2_mism", int'(mismatch_cnt), 2);
    check("e2_code", int'(err_code), 2);
    check("e2_pos", int'(err_pos), 500);

    run_to(1700);
    check("yel_phase", int'(phase), 5);
    run_cycle(1'b1, 3'b001, 1'b0);
    check("yel_pass_pos", int'(pos), 0);
    check("yel_pass_rest", int'(restart_cnt), 1);
    run_cycle(1'b0, 3'b010, 1'b0);
    check("yel_pass_mism", int'(mismatch_cnt), 2);

    run_to(3071);
    run_cycle(1'b1, 3'b100, 1'b0);
    check("last_pass_pos", int'(pos), 0);
    check("last_pass_rest", int'(restart_cnt), 2);
    check("last_pass_wrap", int'(wrap_cnt), 2);

    run_to(2500);
    #2;
    rst = 1'b0;
    #1;
    check("async_pos", int'(pos), 0);
    check("async_err", int'(err), 0);
    check("async_code", int'(err_code), 0);
    check("async_errpos", int'(err_pos), 0);
    check("async_mism", int'(mismatch_cnt), 0);
    check("async_wrap", int'(wrap_cnt), 0);
    check("async_rest", int'(restart_cnt), 0);
    model_reset();
    repeat (2) run_cycle(1'b0, 3'b010, 1'b0);
    rst = 1'b1;

    run_to(10);
    run_cycle(1'b0, 3'b100, 1'b1);
    check("clr_err_err", int'(err), 1);
    check("clr_err_pos", int'(err_pos), 10);
    check("clr_err_code", int'(err_code), 2);
    run_cycle(1'b0, exp_l(m_pos), 1'b1);
    check("clr_only_err", int'(err), 0);
    check("clr_only_mism", int'(mismatch_cnt), 1);

    for (int i = 0; i < 8000; i++) begin
      logic [2:0] l;
      l = exp_l(m_pos);
      if ($urandom_range(0, 49) == 0) l = 3'($urandom_range(0, 7));
      run_cycle(($urandom_range(0, 199) == 0), l, ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
